adder_19bit: RTL and testbench
==============================

Name: adder_19bit

Overview:
- Clocked 19-bit unsigned binary adder: sum = a + b, with carry-out, outputs registered.
- Datapath is an explicit ripple-carry chain of 19 one-bit full-adder cells (generate loop), with no behavioural "+" on the full width.
- Used as a leaf arithmetic block; a valid strobe travels alongside the data so upstream and downstream logic can tell results apart.

Parameters:
- None. Width is fixed at 19 bits; the width is part of the module name.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  operands a/b are valid this cycle
- a  input  19  operand A, unsigned
- b  input  19  operand B, unsigned
- sum  output  19  registered (a + b) mod 2^19
- carry_out  output  1  registered bit 19 of a + b
- out_valid  output  1  sum/carry_out hold a new result this cycle

Behaviour:
- Reset: on a rising clk with rst_n=0, sum=19'h0, carry_out=0 and out_valid=0. Reset overrides in_valid. A result in flight when reset is asserted is discarded.
- Arithmetic: {carry_out, sum} = a + b as a 20-bit unsigned result. Bit 0 has carry-in 0.
- Full-adder cell, per bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)). carry_out = c_19.
- Latency: 1 cycle. If in_valid=1 at edge N, the result appears after edge N together with out_valid=1.
- Hold: if in_valid=0 at an edge, sum and carry_out keep their previous values and out_valid goes to 0.
- Throughput: one addition per cycle. Back-to-back in_valid is allowed. No backpressure; the consumer must take the result in the out_valid cycle.
- Wrap-around: an overflow wraps modulo 2^19 with carry_out=1. Examples: 7FFFF+1 gives sum 0 with carry 1; 7FFFF+7FFFF gives sum 7FFFE with carry 1.
- X handling: a and b are don't-care when in_valid=0.
- No combinational path from any input to any output.

Optional Feature:
- Macro ADDER_19BIT_PIPE_EN.
- Defined:
  - The carry chain is split into two registered stages. Stage 1 computes bits 0..9, registers sum[9:0] and c_10, and registers a[18:10] and b[18:10].
  - Stage 2 computes bits 10..18 and carry_out.
  - Latency becomes 2 cycles; throughput stays 1 per cycle.
  - out_valid is in_valid delayed by 2 cycles.
  - rst_n clears all stage registers and both valid bits.
- Undefined: single-stage, 1-cycle latency as described in Behaviour.
- Arithmetic results are identical in both builds.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, a=b=7FFFF -> sum=0, carry_out=0, out_valid=0 throughout.
- Simple add: a=00001, b=00001, in_valid=1 -> after latency, sum=00002, carry_out=0, out_valid=1.
- Full ripple: a=7FFFF, b=00001 -> sum=00000, carry_out=1.
- Alternating patterns: a=55555, b=2AAAA -> sum=7FFFF, carry_out=0, with no carry generated at any bit.
- Max operands: a=7FFFF, b=7FFFF -> sum=7FFFE, carry_out=1. Then drop in_valid -> sum and carry_out hold, out_valid=0.
- Back-to-back and reset mid-stream:
  - Issue the four vectors above on consecutive cycles; results appear in order on consecutive cycles.
  - Assert rst_n=0 while a result is in flight; it never appears and outputs clear.
  - Run in both builds, with and without ADDER_19BIT_PIPE_EN.

Source files
------------

// File: rtl/adder_19bit.sv
// Registered 19-bit unsigned ripple-carry adder with a valid strobe.
// Define ADDER_19BIT_PIPE_EN to split the carry chain into two registered stages.
module adder_19bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [18:0] a,
    input  logic [18:0] b,
    output logic [18:0] sum,
    output logic        carry_out,
    output logic        out_valid
);

`ifdef ADDER_19BIT_PIPE_EN
    localparam int SPLIT = 10;
`else
    localparam int SPLIT = 19;
`endif

    logic [18:0] fa_a;
    logic [18:0] fa_b;
    logic [18:0] fa_s;
    logic [19:0] carry;
    logic        split_cin;

    assign carry[0] = 1'b0;

    // Bit SPLIT takes its carry-in from the stage register, not from its neighbour.
    for (genvar i = 0; i < 19; i++) begin : g_fa
        logic cin;
        if (i == SPLIT) begin : g_cut
            assign cin = split_cin;
        end else begin : g_link
            assign cin = carry[i];
        end
        assign fa_s[i]    = fa_a[i] ^ fa_b[i] ^ cin;
        assign carry[i+1] = (fa_a[i] & fa_b[i]) | (cin & (fa_a[i] ^ fa_b[i]));
    end

`ifdef ADDER_19BIT_PIPE_EN
    logic [18:10] a_hi_q;
    logic [18:10] b_hi_q;
    logic [9:0]   s_lo_q;
    logic         c10_q;
    logic         v1_q;

    assign fa_a      = {a_hi_q, a[9:0]};
    assign fa_b      = {b_hi_q, b[9:0]};
    assign split_cin = c10_q;

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_hi_q    <= '0;
            b_hi_q    <= '0;
            s_lo_q    <= '0;
            c10_q     <= 1'b0;
            v1_q      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            v1_q      <= in_valid;
            out_valid <= v1_q;
            if (in_valid) begin
                a_hi_q <= a[18:10];
                b_hi_q <= b[18:10];
                s_lo_q <= fa_s[9:0];
                c10_q  <= carry[10];
            end
            if (v1_q) begin
                sum       <= {fa_s[18:10], s_lo_q};
                carry_out <= carry[19];
            end
        end
    end
`else
    assign fa_a      = a;
    assign fa_b      = b;
    assign split_cin = 1'b0;

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= '0;
            carry_out <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum       <= fa_s;
                carry_out <= carry[19];
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_19bit.sv
// Directed self-checking bench for adder_19bit; honours ADDER_19BIT_PIPE_EN for latency.
module tb_adder_19bit;

`ifdef ADDER_19BIT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [18:0] a;
        logic [18:0] b;
        logic [18:0] sum;
        logic        cy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [18:0] a;
    logic [18:0] b;
    logic [18:0] sum;
    logic        carry_out;
    logic        out_valid;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs [7];

    adder_19bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .carry_out (carry_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [18:0] e_sum,
                         input logic e_cy, input logic e_v);
        n_vec++;
        if (sum !== e_sum || carry_out !== e_cy || out_valid !== e_v) begin
            n_err++;
            $display("FAIL %s: got sum=%05h cy=%b v=%b, want sum=%05h cy=%b v=%b",
                     name, sum, carry_out, out_valid, e_sum, e_cy, e_v);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        a = 19'($urandom);
        b = 19'($urandom);
    endtask

    initial begin
        vecs[0] = '{19'h00001, 19'h00001, 19'h00002, 1'b0};
        vecs[1] = '{19'h7FFFF, 19'h00001, 19'h00000, 1'b1};
        vecs[2] = '{19'h55555, 19'h2AAAA, 19'h7FFFF, 1'b0};
        vecs[3] = '{19'h7FFFF, 19'h7FFFF, 19'h7FFFE, 1'b1};
        vecs[4] = '{19'h12345, 19'h54321, 19'h66666, 1'b0};
        vecs[5] = '{19'h40000, 19'h40000, 19'h00000, 1'b1};
        vecs[6] = '{19'h3FFFF, 19'h00001, 19'h40000, 1'b0};

        // Reset dominates a valid max-operand input.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 19'h7FFFF;
        b        = 19'h7FFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset", 19'h0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        idle_inputs();
        step();
        check("post_reset", 19'h0, 1'b0, 1'b0);

        // Isolated vectors: result after LAT edges, then hold with out_valid low.
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            a        = vecs[i].a;
            b        = vecs[i].b;
            step();
            idle_inputs();
            for (int k = 1; k < LAT; k++) step();
            check($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cy, 1'b1);
            step();
            check($sformatf("hold%0d", i), vecs[i].sum, vecs[i].cy, 1'b0);
        end

        // Back-to-back issue of the first four vectors.
        for (int k = 0; k < 4 + LAT - 1; k++) begin
            if (k < 4) begin
                in_valid = 1'b1;
                a        = vecs[k].a;
                b        = vecs[k].b;
            end else begin
                idle_inputs();
            end
            step();
            if (k - (LAT - 1) >= 0)
                check($sformatf("b2b%0d", k - (LAT - 1)),
                      vecs[k - (LAT - 1)].sum, vecs[k - (LAT - 1)].cy, 1'b1);
        end
        idle_inputs();
        step();
        check("b2b_hold", vecs[3].sum, vecs[3].cy, 1'b0);

        // Reset asserted while a result is in flight.
        in_valid = 1'b1;
        a        = 19'h12345;
        b        = 19'h54321;
        step();
        rst_n = 1'b0;
        idle_inputs();
        step();
        check("mid_reset", 19'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 1; k++) begin
            step();
            check("mid_reset_drain", 19'h0, 1'b0, 1'b0);
        end

        // Recovery after reset.
        in_valid = 1'b1;
        a        = vecs[2].a;
        b        = vecs[2].b;
        step();
        idle_inputs();
        for (int k = 1; k < LAT; k++) step();
        check("recover", vecs[2].sum, vecs[2].cy, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
